// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle control sequencer for the RISC core. Latches the opcode on the
// fetch handshake and steps FETCH/DECODE/EXEC/MEM/WB. In each state it drives
// the datapath selects and write strobes, and it stalls in MEM on data-memory
// wait. HALT, illegal opcodes and memory timeouts are trapped in terminal
// states that hold until reset.
module multicycle_control #(
    parameter int unsigned OPCODE_W    = 6,
    parameter int unsigned ALU_CNT_W   = 2,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned RET_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 instr_ready,
    output logic                 ir_wen,
    output logic                 pc_wen,
    output logic [1:0]           pc_cnt,
    output logic                 reg_src,
    output logic                 reg_wen,
    output logic                 alu_src,
    output logic                 check_immed,
    output logic                 w_src,
    output logic                 mem_ren,
    output logic                 mem_wen,
    output logic [ALU_CNT_W-1:0] alu_cnt,
    output logic                 halted,
    output logic [1:0]           fault,
    output logic [RET_W-1:0]     retired
);

    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERR
    } state_t;

    typedef enum logic [2:0] {
        C_RALU   = 3'b000,
        C_IALU   = 3'b001,
        C_LOAD   = 3'b010,
        C_STORE  = 3'b011,
        C_BRANCH = 3'b100,
        C_JUMP   = 3'b101,
        C_HALT   = 3'b110,
        C_ILLEGAL= 3'b111
    } class_t;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JMP  = 2'b10;
    localparam logic [1:0] PC_HOLD = 2'b11;

    localparam logic [1:0] F_NONE    = 2'b00;
    localparam logic [1:0] F_ILLEGAL = 2'b01;
    localparam logic [1:0] F_TIMEOUT = 2'b10;

    state_t                r_state;
    logic [OPCODE_W-1:0]   r_opcode;
    logic [TMO_W-1:0]      r_tmo_cnt;
    logic [RET_W-1:0]      r_retired;
    logic [1:0]            r_fault;
    logic                  r_halted;

    state_t                w_next;
    class_t                w_class;
    logic [ALU_CNT_W-1:0]  w_func;
    logic                  w_imm_class;
    logic                  w_retire;
    logic                  w_halt_set;
    logic [1:0]            w_fault_set;
    logic                  w_tmo_clr;
    logic                  w_tmo_inc;
    logic                  w_unused_opcode;

    assign w_class     = class_t'(r_opcode[OPCODE_W-1 -: 3]);
    assign w_func      = r_opcode[ALU_CNT_W-1:0];
    assign w_imm_class = (w_class == C_IALU) || (w_class == C_LOAD) || (w_class == C_STORE);

    // Opcode bits between the function and class fields are carried but not decoded.
    assign w_unused_opcode = ^r_opcode;

    assign halted  = r_halted;
    assign fault   = r_fault;
    assign retired = r_retired;

    // State register; reset returns to IDLE, so strobes drop with rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode latch, MEM timeout counter, retire counter and sticky trap flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode  <= '0;
            r_tmo_cnt <= '0;
            r_retired <= '0;
            r_fault   <= F_NONE;
            r_halted  <= 1'b0;
        end else begin
            if (ir_wen) begin
                r_opcode <= opcode;
            end
            if (w_tmo_clr) begin
                r_tmo_cnt <= '0;
            end else if (w_tmo_inc) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
            if (w_retire) begin
                r_retired <= r_retired + RET_W'(1);
            end
            if (w_fault_set != F_NONE) begin
                r_fault <= w_fault_set;
            end
            if (w_halt_set) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Next-state, per-state datapath selects and write strobes.
    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_halt_set  = 1'b0;
        w_fault_set = F_NONE;
        w_tmo_clr   = 1'b0;
        w_tmo_inc   = 1'b0;
        instr_ready = 1'b0;
        ir_wen      = 1'b0;
        pc_wen      = 1'b0;
        pc_cnt      = PC_HOLD;
        reg_src     = 1'b0;
        reg_wen     = 1'b0;
        alu_src     = 1'b0;
        check_immed = 1'b0;
        w_src       = 1'b0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        alu_cnt     = '0;

        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end

            S_FETCH: begin
                instr_ready = 1'b1;
                ir_wen      = instr_valid;
                if (instr_valid) begin
                    pc_wen = 1'b1;
                    pc_cnt = PC_INC;
                    w_next = S_DECODE;
                end
            end

            S_DECODE: begin
                if (w_class == C_ILLEGAL) begin
                    w_next      = S_ERR;
                    w_fault_set = F_ILLEGAL;
                end else if (w_class == C_HALT) begin
                    w_next     = S_HALT;
                    w_halt_set = 1'b1;
                    w_retire   = 1'b1;
                end else begin
                    w_next = S_EXEC;
                end
            end

            S_EXEC: begin
                alu_cnt     = w_func;
                alu_src     = w_imm_class;
                check_immed = w_imm_class;
                case (w_class)
                    C_RALU, C_IALU: begin
                        w_next = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        w_next    = S_MEM;
                        w_tmo_clr = 1'b1;
                    end
                    C_BRANCH: begin
                        if (zero) begin
                            pc_wen = 1'b1;
                            pc_cnt = PC_BR;
                        end
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                    C_JUMP: begin
                        pc_wen   = 1'b1;
                        pc_cnt   = PC_JMP;
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                    default: begin
                        // HALT/illegal never reach EXEC; trap defensively.
                        w_next      = S_ERR;
                        w_fault_set = F_ILLEGAL;
                    end
                endcase
            end

            S_MEM: begin
                mem_ren = (w_class == C_LOAD);
                mem_wen = (w_class == C_STORE);
                // A ready arriving on the last permitted wait cycle completes normally.
                if (mem_ready) begin
                    if (w_class == C_LOAD) begin
                        w_next = S_WB;
                    end else begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                end else if (r_tmo_cnt == TMO_W'(MEM_TIMEOUT)) begin
                    w_next      = S_ERR;
                    w_fault_set = F_TIMEOUT;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end

            S_WB: begin
                reg_wen  = 1'b1;
                reg_src  = (w_class == C_IALU) || (w_class == C_LOAD);
                w_src    = (w_class == C_LOAD);
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end

            S_HALT, S_ERR: begin
                w_next = r_state;
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
